// File: rtl/datapath_xyz_if.sv
// Control-code, operand and observe signals between the control FSM (master) and the X/Y/Z datapath (slave).
// No handshake: codes and data_in are sampled on every clock edge.
interface datapath_xyz_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [3:0]       tx;
    logic [3:0]       ty;
    logic [3:0]       tz;
    logic [3:0]       tula;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] acc_out;
    logic             carry;
    logic             zero;
    logic             z_valid;
    logic [CNT_W-1:0] result_count;

    modport master (
        output tx, ty, tz, tula, data_in,
        input  data_out, acc_out, carry, zero, z_valid, result_count
    );

    modport slave (
        input  tx, ty, tz, tula, data_in,
        output data_out, acc_out, carry, zero, z_valid, result_count
    );
endinterface

// File: rtl/datapath_xyz.sv
// X/Y/Z register + ULA datapath; every register updates in parallel on one edge and data_out is Z directly (0-cycle latency).
// No back-pressure: codes and data_in are consumed on every edge.
module datapath_xyz #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic          i_clock,
    input  logic          i_reset,
    datapath_xyz_if.slave io_dp
);
    localparam logic [3:0] C_CLEAR  = 4'd0;
    localparam logic [3:0] C_LOAD   = 4'd1;
    localparam logic [3:0] C_SHIFTR = 4'd3;

    localparam logic [3:0] U_SUB  = 4'd1;
    localparam logic [3:0] U_AND  = 4'd2;
    localparam logic [3:0] U_OR   = 4'd3;
    localparam logic [3:0] U_XOR  = 4'd4;
    localparam logic [3:0] U_PASS = 4'd5;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic             r_carry;
    logic             r_z_valid;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH:0]   w_ula;

    // Top bit is carry for ADD, borrow for SUB, and always 0 for logic ops.
    always_comb begin
        w_ula = {1'b0, r_y} + {1'b0, r_x};
        case (io_dp.tula)
            U_SUB:   w_ula = {1'b0, r_y} - {1'b0, r_x};
            U_AND:   w_ula = {1'b0, r_y & r_x};
            U_OR:    w_ula = {1'b0, r_y | r_x};
            U_XOR:   w_ula = {1'b0, r_y ^ r_x};
            U_PASS:  w_ula = {1'b0, r_x};
            default: w_ula = {1'b0, r_y} + {1'b0, r_x};
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_x <= '0;
        end else begin
            case (io_dp.tx)
                C_CLEAR:  r_x <= '0;
                C_LOAD:   r_x <= io_dp.data_in;
                C_SHIFTR: r_x <= {1'b0, r_x[WIDTH-1:1]};
                default:  r_x <= r_x;
            endcase
        end
    end

    // Y shift pulls the saved carry into the MSB so (a+b)>>1 keeps the sum's top bit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_y     <= '0;
            r_carry <= 1'b0;
        end else begin
            case (io_dp.ty)
                C_CLEAR: begin
                    r_y     <= '0;
                    r_carry <= 1'b0;
                end
                C_LOAD: begin
                    r_y     <= w_ula[WIDTH-1:0];
                    r_carry <= w_ula[WIDTH];
                end
                C_SHIFTR: begin
                    r_y     <= {r_carry, r_y[WIDTH-1:1]};
                    r_carry <= 1'b0;
                end
                default: begin
                    r_y     <= r_y;
                    r_carry <= r_carry;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_z       <= '0;
            r_z_valid <= 1'b0;
            r_count   <= '0;
        end else begin
            r_z_valid <= (io_dp.tz == C_LOAD);
            if (io_dp.tz == C_LOAD) begin
                r_count <= r_count + CNT_ONE;
            end
            case (io_dp.tz)
                C_CLEAR:  r_z <= '0;
                C_LOAD:   r_z <= r_y;
                C_SHIFTR: r_z <= {1'b0, r_z[WIDTH-1:1]};
                default:  r_z <= r_z;
            endcase
        end
    end

    assign io_dp.data_out     = r_z;
    assign io_dp.acc_out      = r_y;
    assign io_dp.carry        = r_carry;
    assign io_dp.zero         = (r_y == '0);
    assign io_dp.z_valid      = r_z_valid;
    assign io_dp.result_count = r_count;
endmodule

// File: tb/tb_datapath_xyz.sv
// Directed-vector bench for datapath_xyz with hand-computed expectations.
module tb_datapath_xyz;
    localparam logic [3:0] CLR = 4'd0;
    localparam logic [3:0] LD  = 4'd1;
    localparam logic [3:0] HD  = 4'd2;
    localparam logic [3:0] SR  = 4'd3;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    datapath_xyz_if #(.WIDTH(16), .CNT_W(8)) dp_if ();

    datapath_xyz #(.WIDTH(16), .CNT_W(8)) dut (
        .i_clock (clock),
        .i_reset (reset),
        .io_dp   (dp_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] op, input logic [15:0] din);
        dp_if.tx      = a;
        dp_if.ty      = b;
        dp_if.tz      = c;
        dp_if.tula    = op;
        dp_if.data_in = din;
        @(posedge clock);
        #1;
    endtask

    // Full average sequence: clear, load a, load b + Y=a, Y=a+b, shift, Z load.
    task automatic avg_seq(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] e_y1, input logic [15:0] e_y2, input logic e_c2,
                           input logic [15:0] e_avg, input logic [7:0] e_cnt);
        step(CLR, CLR, HD, 4'd0, 16'd0);
        step(LD,  HD,  HD, 4'd0, a);
        step(LD,  LD,  HD, 4'd0, b);
        check_eq({tag, "_y_a"}, dp_if.acc_out, e_y1);
        step(HD,  LD,  HD, 4'd0, 16'd0);
        check_eq({tag, "_y_sum"}, dp_if.acc_out, e_y2);
        check_eq({tag, "_c_sum"}, dp_if.carry, e_c2);
        step(HD,  SR,  HD, 4'd0, 16'd0);
        check_eq({tag, "_y_avg"}, dp_if.acc_out, e_avg);
        check_eq({tag, "_c_shift"}, dp_if.carry, 1'b0);
        step(HD,  HD,  LD, 4'd0, 16'd0);
        check_eq({tag, "_z"}, dp_if.data_out, e_avg);
        check_eq({tag, "_zvld"}, dp_if.z_valid, 1'b1);
        check_eq({tag, "_cnt"}, dp_if.result_count, e_cnt);
        step(HD,  HD,  HD, 4'd0, 16'd0);
        check_eq({tag, "_zvld_drop"}, dp_if.z_valid, 1'b0);
    endtask

    logic [3:0]  log_op  [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
    logic [15:0] log_exp [4] = '{16'h000F, 16'h0FFF, 16'h0FF0, 16'h00FF};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        dp_if.tx = HD; dp_if.ty = HD; dp_if.tz = HD; dp_if.tula = 4'd0; dp_if.data_in = 16'd0;
        #1;
        check_eq("rst_dout", dp_if.data_out, 16'd0);
        check_eq("rst_acc", dp_if.acc_out, 16'd0);
        check_eq("rst_zero", dp_if.zero, 1'b1);
        check_eq("rst_cnt", dp_if.result_count, 8'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        avg_seq("avg_10_20", 16'd10, 16'd20, 16'd10, 16'd30, 1'b0, 16'd15, 8'd1);
        avg_seq("avg_ffff", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 16'hFFFF, 8'd2);

        // SUB with borrow: 5 - 7
        step(CLR, CLR, HD, 4'd0, 16'd0);
        check_eq("clr_zero", dp_if.zero, 1'b1);
        step(LD, HD, HD, 4'd0, 16'd5);
        step(LD, LD, HD, 4'd0, 16'd7);
        check_eq("sub_pre_y", dp_if.acc_out, 16'd5);
        step(HD, LD, HD, 4'd1, 16'd0);
        check_eq("sub_y", dp_if.acc_out, 16'hFFFE);
        check_eq("sub_borrow", dp_if.carry, 1'b1);

        // Logic ops from Y=0x0F0F (carry set by ADD) and X=0x00FF
        for (int i = 0; i < 4; i++) begin
            step(LD, CLR, HD, 4'd0, 16'h0F10);
            step(LD, LD,  HD, 4'd0, 16'hFFFF);
            step(LD, LD,  HD, 4'd0, 16'h00FF);
            check_eq("logic_pre_c", dp_if.carry, 1'b1);
            step(HD, LD, HD, log_op[i], 16'd0);
            check_eq("logic_y", dp_if.acc_out, log_exp[i]);
            check_eq("logic_c", dp_if.carry, 1'b0);
        end

        // Asynchronous reset mid-sequence, away from any clock edge
        step(CLR, CLR, HD, 4'd0, 16'd0);
        step(LD, HD, HD, 4'd0, 16'd10);
        step(LD, LD, HD, 4'd0, 16'd20);
        step(HD, LD, HD, 4'd0, 16'd0);
        check_eq("arst_pre_y", dp_if.acc_out, 16'd30);
        check_eq("arst_pre_z", dp_if.data_out, 16'hFFFF);
        reset = 1'b1;
        #1;
        check_eq("arst_acc", dp_if.acc_out, 16'd0);
        check_eq("arst_dout", dp_if.data_out, 16'd0);
        check_eq("arst_carry", dp_if.carry, 1'b0);
        check_eq("arst_zero", dp_if.zero, 1'b1);
        check_eq("arst_zvld", dp_if.z_valid, 1'b0);
        check_eq("arst_cnt", dp_if.result_count, 8'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        avg_seq("avg_4_6", 16'd4, 16'd6, 16'd4, 16'd10, 1'b0, 16'd5, 8'd1);

        // Unknown codes hold everything (X=6, Y=5, Z=5)
        step(4'd7,  4'd15, 4'd7,  4'd0, 16'hBEEF);
        step(4'd15, 4'd7,  4'd15, 4'd0, 16'hBEEF);
        step(4'd7,  4'd7,  4'd15, 4'd0, 16'hBEEF);
        check_eq("hold_y", dp_if.acc_out, 16'd5);
        check_eq("hold_z", dp_if.data_out, 16'd5);
        check_eq("hold_cnt", dp_if.result_count, 8'd1);
        check_eq("hold_zvld", dp_if.z_valid, 1'b0);
        step(HD, LD, HD, 4'd5, 16'd0);
        check_eq("hold_x_pass", dp_if.acc_out, 16'd6);
        step(SR, HD, LD, 4'd0, 16'd0);
        check_eq("zload_6", dp_if.data_out, 16'd6);
        step(HD, LD, SR, 4'd5, 16'd0);
        check_eq("xshift_pass", dp_if.acc_out, 16'd3);
        check_eq("zshift", dp_if.data_out, 16'd3);
        step(HD, HD, CLR, 4'd0, 16'd0);
        check_eq("zclear", dp_if.data_out, 16'd0);
        check_eq("zclear_cnt", dp_if.result_count, 8'd2);

        // Counter wrap
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 255; i++) begin
            step(HD, HD, LD, 4'd0, 16'd0);
        end
        check_eq("cnt_255", dp_if.result_count, 8'd255);
        step(HD, HD, LD, 4'd0, 16'd0);
        check_eq("cnt_wrap", dp_if.result_count, 8'd0);
        check_eq("cnt_wrap_zvld", dp_if.z_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
